// File: rtl/mac_vector_feeder.sv
// Collects element pairs into packed operand vectors, requests a MAC operation,
// guards it with a watchdog and holds the result until it is consumed downstream.
module mac_vector_feeder #(
    parameter int DATA_WIDTH     = 4,
    parameter int ACC_WIDTH      = 20,
    parameter int VECTOR_SIZE    = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [DATA_WIDTH-1:0]                  in_a,
    input  logic [DATA_WIDTH-1:0]                  in_b,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] mac_a_out,
    output logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] mac_b_out,
    output logic                                   mac_start,
    input  logic [ACC_WIDTH-1:0]                   mac_result,
    input  logic                                   mac_done,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [ACC_WIDTH-1:0]                   res_data,
    output logic                                   timeout_err
);

    localparam int LANE_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] FILL = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] HOLD = 2'b10;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR_SIZE - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]                            r_state;
    logic [LANE_W-1:0]                     r_lane;
    logic [WDOG_W-1:0]                     r_wdog;
    logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] r_mac_a;
    logic [VECTOR_SIZE-1:0][DATA_WIDTH-1:0] r_mac_b;
    logic                                  r_in_ready;
    logic                                  r_mac_start;
    logic                                  r_res_valid;
    logic [ACC_WIDTH-1:0]                  r_res_data;
    logic                                  r_timeout_err;

    logic w_accept;
    logic w_last_lane;
    logic w_expire;

    // Acceptance is qualified by the state itself so in_valid outside FILL is inert.
    assign w_accept    = in_valid && (r_state == FILL);
    assign w_last_lane = (r_lane == LAST_LANE);
    assign w_expire    = (r_wdog == WDOG_LAST);

    // Control FSM, lane/watchdog counters and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FILL;
            r_lane        <= '0;
            r_wdog        <= '0;
            r_mac_a       <= '0;
            r_mac_b       <= '0;
            r_in_ready    <= 1'b1;
            r_mac_start   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_mac_a[r_lane] <= in_a;
                        r_mac_b[r_lane] <= in_b;
                        if (w_last_lane) begin
                            r_lane      <= '0;
                            r_wdog      <= '0;
                            r_state     <= BUSY;
                            r_in_ready  <= 1'b0;
                            r_mac_start <= 1'b1;
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end
                BUSY: begin
                    // A done on the expiry edge wins over the watchdog.
                    if (mac_done) begin
                        r_res_data  <= mac_result;
                        r_res_valid <= 1'b1;
                        r_mac_start <= 1'b0;
                        r_state     <= HOLD;
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_mac_start   <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_state       <= FILL;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= FILL;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_lane      <= '0;
                    r_wdog      <= '0;
                    r_in_ready  <= 1'b1;
                    r_mac_start <= 1'b0;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign mac_a_out   = r_mac_a;
    assign mac_b_out   = r_mac_b;
    assign mac_start   = r_mac_start;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Bench for mac_vector_feeder: table of vectors, hand-written corner sequences,
// a behavioural MAC responder and a result scoreboard.
module tb_mac_vector_feeder;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic [1:0][3:0]  mac_a_out;
    logic [1:0][3:0]  mac_b_out;
    logic             mac_start;
    logic [19:0]      mac_result;
    logic             mac_done;
    logic             res_valid;
    logic             res_ready;
    logic [19:0]      res_data;
    logic             timeout_err;

    mac_vector_feeder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .mac_a_out   (mac_a_out),
        .mac_b_out   (mac_b_out),
        .mac_start   (mac_start),
        .mac_result  (mac_result),
        .mac_done    (mac_done),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a0, b0, a1, b1;
        logic [7:0] ea, eb;
        int         res;
    } vec_t;

    vec_t tbl[6];
    int   sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mac_delay = 3;   // 0 = MAC never answers
    bit   spurious = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural MAC: answers mac_delay cycles after start with the dot product.
    initial begin
        int cnt;
        int dot;
        cnt = 0;
        mac_done = 1'b0;
        mac_result = 20'd0;
        forever begin
            @(negedge clk);
            if (mac_start && mac_delay != 0) begin
                cnt++;
                dot = int'(mac_a_out[0]) * int'(mac_b_out[0]) + int'(mac_a_out[1]) * int'(mac_b_out[1]);
                mac_result = 20'(dot);
                mac_done = (cnt == mac_delay);
            end else begin
                cnt = 0;
                mac_done = spurious;
                mac_result = 20'hABCDE;
            end
        end
    end

    task automatic feed(input logic [3:0] a, input logic [3:0] b);
        int w;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) check("feed_wait", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_vec(input logic [7:0] ea, input logic [7:0] eb, input int d, input string tag);
        int lat;
        int unstable;
        int exp_res;
        check({tag, "_start"}, 64'(mac_start), 64'd1);
        check({tag, "_inrdy0"}, 64'(in_ready), 64'd0);
        check({tag, "_a"}, 64'(mac_a_out), 64'(ea));
        check({tag, "_b"}, 64'(mac_b_out), 64'(eb));
        lat = 0;
        unstable = 0;
        while (!res_valid && lat < 200) begin
            if (mac_a_out !== ea || mac_b_out !== eb || mac_start !== 1'b1) unstable++;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(d));
        check({tag, "_stable"}, 64'(unstable), 64'd0);
        check({tag, "_start_drop"}, 64'(mac_start), 64'd0);
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            exp_res = sb.pop_front();
            check({tag, "_res"}, 64'(res_data), 64'(exp_res));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_rv_clr"}, 64'(res_valid), 64'd0);
        check({tag, "_inrdy1"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int d, input string tag);
        mac_delay = d;
        sb.push_back(v.res);
        feed(v.a0, v.b0);
        feed(v.a1, v.b1);
        finish_vec(v.ea, v.eb, d, tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_a"}, 64'(mac_a_out), 64'd0);
        check({tag, "_b"}, 64'(mac_b_out), 64'd0);
        check({tag, "_start"}, 64'(mac_start), 64'd0);
        check({tag, "_rv"}, 64'(res_valid), 64'd0);
        check({tag, "_rd"}, 64'(res_data), 64'd0);
        check({tag, "_to"}, 64'(timeout_err), 64'd0);
        check({tag, "_inrdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        vec_t v;
        tbl[0] = '{4'd15, 4'd2,  4'd10, 4'd1, 8'hAF, 8'h12, 40};
        tbl[1] = '{4'd0,  4'd0,  4'd0,  4'd0, 8'h00, 8'h00, 0};
        tbl[2] = '{4'd15, 4'd15, 4'd15, 4'd15, 8'hFF, 8'hFF, 450};
        tbl[3] = '{4'd1,  4'd2,  4'd3,  4'd4, 8'h31, 8'h42, 14};
        tbl[4] = '{4'd7,  4'd9,  4'd0,  4'd5, 8'h07, 8'h59, 63};
        tbl[5] = '{4'd8,  4'd1,  4'd2,  4'd8, 8'h28, 8'h81, 24};

        reset = 1'b1;
        in_valid = 1'b0;
        in_a = 4'd0;
        in_b = 4'd0;
        res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(tbl[i], 1 + (i % 4), $sformatf("vec%0d", i));
        end

        // Gapped input: valid 1,0,0,1.
        mac_delay = 2;
        sb.push_back(25);
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
        @(negedge clk);
        in_valid = 1'b0; in_a = 4'd9; in_b = 4'd9;
        @(negedge clk);
        @(negedge clk);
        check("gap_nostart", 64'(mac_start), 64'd0);
        check("gap_inrdy", 64'(in_ready), 64'd1);
        feed(4'd4, 4'd4);
        finish_vec(8'h43, 8'h43, 2, "gap");

        // Backpressure with in_valid offered during HOLD.
        mac_delay = 3;
        sb.push_back(40);
        feed(4'd15, 4'd2);
        feed(4'd10, 4'd1);
        cnt = 0;
        while (!res_valid && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_rv", 64'(res_valid), 64'd1);
        if (sb.size() != 0) check("bp_res", 64'(res_data), 64'(sb.pop_front()));
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1;
            @(negedge clk);
            check($sformatf("bp_hold_rv%0d", k), 64'(res_valid), 64'd1);
            check($sformatf("bp_hold_rd%0d", k), 64'(res_data), 64'd40);
            check($sformatf("bp_hold_ir%0d", k), 64'(in_ready), 64'd0);
            check($sformatf("bp_hold_a%0d", k), 64'(mac_a_out), 64'hAF);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_rv_clr", 64'(res_valid), 64'd0);
        check("bp_inrdy", 64'(in_ready), 64'd1);

        // Spurious done during FILL.
        spurious = 1'b1;
        mac_delay = 2;
        repeat (3) @(negedge clk);
        check("spur_rv", 64'(res_valid), 64'd0);
        check("spur_inrdy", 64'(in_ready), 64'd1);
        check("spur_start", 64'(mac_start), 64'd0);
        check("spur_rd", 64'(res_data), 64'd40);
        sb.push_back(26);
        feed(4'd5, 4'd5);
        check("spur_mid_inrdy", 64'(in_ready), 64'd1);
        check("spur_mid_rv", 64'(res_valid), 64'd0);
        spurious = 1'b0;
        feed(4'd1, 4'd1);
        finish_vec(8'h15, 8'h15, 2, "spur");

        // Timeout: the MAC never answers.
        mac_delay = 0;
        feed(4'd1, 4'd1);
        feed(4'd2, 4'd2);
        cnt = 0;
        while (mac_start && cnt < 200) begin
            if (res_valid !== 1'b0) check("to_rv_busy", 64'(res_valid), 64'd0);
            @(negedge clk);
            cnt++;
        end
        check("to_busy_cycles", 64'(cnt), 64'd64);
        check("to_err", 64'(timeout_err), 64'd1);
        check("to_rv", 64'(res_valid), 64'd0);
        check("to_rd", 64'(res_data), 64'd26);
        check("to_inrdy", 64'(in_ready), 64'd1);
        check("to_sb_empty", 64'(sb.size()), 64'd0);
        run_vec(tbl[3], 3, "after_to");
        check("to_sticky", 64'(timeout_err), 64'd1);

        // Reset in the middle of BUSY.
        mac_delay = 10;
        feed(4'd9, 4'd9);
        feed(4'd9, 4'd9);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_busy");
        @(negedge clk);
        reset = 1'b0;
        v = '{4'd2, 4'd3, 4'd4, 4'd5, 8'h42, 8'h53, 26};
        run_vec(v, 3, "post_rst");

        // Partially filled vector discarded by reset.
        feed(4'd9, 4'd7);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_part");
        @(negedge clk);
        reset = 1'b0;
        run_vec(v, 2, "post_part");

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_vector_feeder.md
MAC_VECTOR_FEEDER -- requirements
Module: mac_vector_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, width of one operand element.
REQ-002 SHALL have parameter ACC_WIDTH, default 20, width of the MAC result.
REQ-003 SHALL have parameter VECTOR_SIZE, default 2, number of elements per MAC vector (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of BUSY cycles to wait for mac_done (>=2).
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in_valid  input  1  an element pair is offered.
REQ-008 SHALL have port in_ready  output  1  the feeder accepts the offered element pair.
REQ-009 SHALL have port in_a  input  DATA_WIDTH  operand A element.
REQ-010 SHALL have port in_b  input  DATA_WIDTH  operand B element.
REQ-011 SHALL have port mac_a_out  output  [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]  packed A vector driven to the MAC.
REQ-012 SHALL have port mac_b_out  output  [VECTOR_SIZE-1:0][DATA_WIDTH-1:0]  packed B vector driven to the MAC.
REQ-013 SHALL have port mac_start  output  1  MAC start request.
REQ-014 SHALL have port mac_result  input  ACC_WIDTH  MAC result.
REQ-015 SHALL have port mac_done  input  1  MAC completion flag.
REQ-016 SHALL have port res_valid  output  1  res_data holds an unconsumed result.
REQ-017 SHALL have port res_ready  input  1  downstream consumes the result.
REQ-018 SHALL have port res_data  output  ACC_WIDTH  captured MAC result.
REQ-019 SHALL have port timeout_err  output  1  sticky flag: a MAC operation timed out.

Function
REQ-020 SHALL implement a state machine with states FILL, BUSY and HOLD.
REQ-021 In FILL, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-022 An element SHALL be accepted on a rising edge where in_valid and in_ready are both 1; the k-th accepted element (k=0..VECTOR_SIZE-1) SHALL be written to lane k of mac_a_out/mac_b_out, lane 0 at the LSBs.
REQ-023 A lane counter SHALL count accepted elements; on acceptance of lane VECTOR_SIZE-1 the counter SHALL wrap to 0 and the state SHALL go FILL->BUSY on the same edge.
REQ-024 mac_a_out/mac_b_out SHALL be registered and SHALL be held stable for the whole of BUSY.
REQ-025 mac_start SHALL be 1 exactly while in BUSY (level request, held until done is seen) and 0 otherwise.
REQ-026 In BUSY, on an edge with mac_done=1, mac_result SHALL be captured into res_data, res_valid SHALL be set to 1, and the state SHALL go to HOLD.
REQ-027 A watchdog counter SHALL clear on BUSY entry and increment each BUSY cycle; if TIMEOUT_CYCLES BUSY cycles elapse without mac_done, timeout_err SHALL be set, res_data SHALL be left unchanged, res_valid SHALL stay 0, and the state SHALL return to FILL.
REQ-028 mac_done arriving on the same edge as the watchdog expiry SHALL take priority: the result is captured and timeout_err SHALL NOT be set.
REQ-029 In HOLD, res_valid and res_data SHALL be held until an edge with res_ready=1, which SHALL clear res_valid and return to FILL.
REQ-030 mac_done outside BUSY SHALL be ignored.
REQ-031 in_valid outside FILL SHALL be ignored and SHALL NOT alter the lane registers.
REQ-032 Minimum latency SHALL be: last element accepted at edge N, mac_start=1 from edge N, res_valid=1 one edge after mac_done is sampled high.
REQ-033 timeout_err SHALL be cleared only by reset.

Reset
REQ-034 On reset assertion, asynchronously: state=FILL, lane and watchdog counters=0, mac_a_out=0, mac_b_out=0, mac_start=0, res_valid=0, res_data=0, timeout_err=0; in_ready SHALL be 1 once in FILL.
REQ-035 Reset asserted mid-BUSY or mid-HOLD SHALL abandon the operation; a partially filled vector SHALL be discarded.

Verification
REQ-036 Defaults: feed (a=15,b=2) then (10,1); bench MAC asserts done 3 cycles after start with 40 -> mac_a_out=8'hAF, mac_b_out=8'h12, mac_start high until done, res_data=40, res_valid=1.
REQ-037 Backpressure: hold res_ready=0 for 5 cycles after a result -> res_valid/res_data stable, in_ready=0; res_ready=1 -> res_valid=0, in_ready=1 on the next cycle.
REQ-038 Timeout: MAC never asserts done -> after 64 BUSY cycles timeout_err=1, res_valid=0, state FILL, next vector processed normally with timeout_err still 1.
REQ-039 Gapped input: in_valid toggled 1,0,0,1 with elements (3,3),(4,4) -> vector completes only after the second accepted element; mac_a_out=8'h43.
REQ-040 Reset during BUSY -> all outputs return to reset values immediately; a fresh two-element vector then yields the correct result.
REQ-041 Spurious done: assert mac_done during FILL -> res_valid stays 0 and no state change.
